// File: rtl/tile_rom_fetch_arbiter.sv
// tile_rom_fetch_arbiter: round-robin arbiter turning per-layer tile fetch
// toggles into 64-bit graphics ROM fetches, with blank-tile bypass and a
// one-entry word cache in front of the toggle req/ack ROM port.

// Per-channel address former and blank detector.
module tile_rom_fetch_lane #(
    parameter int                 CODE_W     = 16,
    parameter int                 ROW_W      = 4,
    parameter int                 ADDR_LSB   = 3,
    parameter int                 BLANK_EN   = 1,
    parameter logic [CODE_W-1:0]  BLANK_MASK = 16'h7FFF
) (
    input  logic [CODE_W-1:0]                code,
    input  logic [ROW_W-1:0]                 row,
    input  logic                             flipy,
    output logic [CODE_W+ROW_W+ADDR_LSB-1:0] addr,
    output logic                             blank
);
    // Vertical flip mirrors the row index inside the tile.
    assign addr  = {code, row ^ {ROW_W{flipy}}, {ADDR_LSB{1'b0}}};
    assign blank = (BLANK_EN != 0) && ((code & BLANK_MASK) == '0);
endmodule

module tile_rom_fetch_arbiter #(
    parameter int                 NUM_CH     = 4,
    parameter int                 CODE_W     = 16,
    parameter int                 ROW_W      = 4,
    parameter int                 ADDR_LSB   = 3,
    parameter int                 DATA_W     = 64,
    parameter int                 BLANK_EN   = 1,
    parameter logic [CODE_W-1:0]  BLANK_MASK = 16'h7FFF,
    parameter int                 CACHE_EN   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH-1:0]                ch_req,
    output logic [NUM_CH-1:0]                ch_ack,
    input  logic [NUM_CH*CODE_W-1:0]         ch_code,
    input  logic [NUM_CH*ROW_W-1:0]          ch_row,
    input  logic [NUM_CH-1:0]                ch_flipy,
    input  logic                             cache_flush,
    output logic [CODE_W+ROW_W+ADDR_LSB-1:0] rom_address,
    output logic                             rom_req,
    input  logic                             rom_ack,
    input  logic [DATA_W-1:0]                rom_data,
    output logic                             load,
    output logic [$clog2(NUM_CH)-1:0]        load_ch,
    output logic [DATA_W-1:0]                load_data,
    output logic                             busy
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int A_W  = CODE_W + ROW_W + ADDR_LSB;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                    state, state_nx;
    logic [CH_W-1:0]           rr_ptr, rr_nx;
    logic                      cache_valid, valid_nx;
    logic [A_W-1:0]            cache_tag, tag_nx;
    logic [DATA_W-1:0]         cache_data, cdata_nx;
    logic [CH_W-1:0]           wait_ch, wch_nx;
    logic [A_W-1:0]            wait_addr, waddr_nx;
    logic [NUM_CH-1:0]         ack_nx;
    logic                      rom_req_nx, load_nx, busy_nx;
    logic [A_W-1:0]            rom_addr_nx;
    logic [CH_W-1:0]           load_ch_nx;
    logic [DATA_W-1:0]         load_data_nx;

    logic [NUM_CH-1:0][A_W-1:0] lane_addr;
    logic [NUM_CH-1:0]          lane_blank;
    logic [NUM_CH-1:0]          pending;
    logic                       any_pend;
    logic [CH_W-1:0]            win;
    logic [CH_W:0]              idx;
    logic [A_W-1:0]             win_addr;
    logic                       win_blank, win_hit;
    logic [CH_W-1:0]            win_next;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            tile_rom_fetch_lane #(
                .CODE_W(CODE_W), .ROW_W(ROW_W), .ADDR_LSB(ADDR_LSB),
                .BLANK_EN(BLANK_EN), .BLANK_MASK(BLANK_MASK)
            ) u_lane (
                .code (ch_code[g*CODE_W +: CODE_W]),
                .row  (ch_row[g*ROW_W +: ROW_W]),
                .flipy(ch_flipy[g]),
                .addr (lane_addr[g]),
                .blank(lane_blank[g])
            );
        end
    endgenerate

    assign pending = ch_req ^ ch_ack;

    // Round-robin pick: walk downward so the channel nearest rr_ptr is kept last.
    always_comb begin
        any_pend = 1'b0;
        win      = '0;
        idx      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(NUM_CH))
                idx = idx - (CH_W+1)'(NUM_CH);
            if (pending[idx[CH_W-1:0]]) begin
                any_pend = 1'b1;
                win      = idx[CH_W-1:0];
            end
        end
    end

    assign win_addr  = lane_addr[win];
    assign win_blank = lane_blank[win];
    assign win_hit   = (CACHE_EN != 0) && cache_valid && (cache_tag == win_addr) && !cache_flush;
    assign win_next  = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);

    // Next-state and output decode; everything defaults to hold except load.
    always_comb begin
        state_nx     = state;
        rr_nx        = rr_ptr;
        valid_nx     = cache_valid;
        tag_nx       = cache_tag;
        cdata_nx     = cache_data;
        wch_nx       = wait_ch;
        waddr_nx     = wait_addr;
        ack_nx       = ch_ack;
        rom_req_nx   = rom_req;
        rom_addr_nx  = rom_address;
        load_nx      = 1'b0;
        load_ch_nx   = load_ch;
        load_data_nx = load_data;
        busy_nx      = busy;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    rr_nx = win_next;
                    if (win_blank || win_hit) begin
                        load_nx      = 1'b1;
                        load_ch_nx   = win;
                        load_data_nx = win_blank ? '0 : cache_data;
                        ack_nx[win]  = ~ch_ack[win];
                    end else begin
                        rom_addr_nx = win_addr;
                        rom_req_nx  = ~rom_req;
                        busy_nx     = 1'b1;
                        wch_nx      = win;
                        waddr_nx    = win_addr;
                        state_nx    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (rom_ack == rom_req) begin
                    load_nx         = 1'b1;
                    load_ch_nx      = wait_ch;
                    load_data_nx    = rom_data;
                    ack_nx[wait_ch] = ~ch_ack[wait_ch];
                    busy_nx         = 1'b0;
                    tag_nx          = wait_addr;
                    cdata_nx        = rom_data;
                    valid_nx        = 1'b1;
                    state_nx        = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A flush beats a simultaneous fill.
        if (cache_flush)
            valid_nx = 1'b0;
    end

    // State and datapath registers; reset drops pending work and any in-flight fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
            wait_ch     <= '0;
            wait_addr   <= '0;
            ch_ack      <= ch_req;
            rom_req     <= rom_ack;
            rom_address <= '0;
            load        <= 1'b0;
            load_ch     <= '0;
            load_data   <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_nx;
            cache_valid <= valid_nx;
            cache_tag   <= tag_nx;
            cache_data  <= cdata_nx;
            wait_ch     <= wch_nx;
            wait_addr   <= waddr_nx;
            ch_ack      <= ack_nx;
            rom_req     <= rom_req_nx;
            rom_address <= rom_addr_nx;
            load        <= load_nx;
            load_ch     <= load_ch_nx;
            load_data   <= load_data_nx;
            busy        <= busy_nx;
        end
    end
endmodule

// File: tb/tb_tile_rom_fetch_arbiter.sv
// Self-checking bench for tile_rom_fetch_arbiter: directed scenarios then
// random producer/ROM traffic, compared every cycle against a transaction model.
module tb_tile_rom_fetch_arbiter;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int RW  = 4;
    localparam int AW  = 23;
    localparam int DW  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    ch_req = '0;
    logic [NCH-1:0]    ch_ack;
    logic [CW-1:0]     code [NCH];
    logic [RW-1:0]     row [NCH];
    logic [NCH-1:0]    ch_flipy = '0;
    logic [NCH*CW-1:0] ch_code;
    logic [NCH*RW-1:0] ch_row;
    logic              cache_flush = 1'b0;
    logic [AW-1:0]     rom_address;
    logic              rom_req;
    logic              rom_ack = 1'b1;
    logic [DW-1:0]     rom_data = '0;
    logic              load;
    logic [1:0]        load_ch;
    logic [DW-1:0]     load_data;
    logic              busy;

    int checks = 0;
    int failures = 0;

    // model state
    logic [NCH-1:0] m_ack;
    logic           m_romreq;
    logic [AW-1:0]  m_addr;
    logic           m_load;
    int             m_load_ch;
    logic [DW-1:0]  m_load_data;
    logic           m_busy;
    int             m_rr;
    logic           m_valid;
    logic [AW-1:0]  m_tag;
    logic [DW-1:0]  m_cdata;
    int             m_out = -1;
    logic [AW-1:0]  m_out_addr;
    logic           m_new_fetch;
    logic           m_after_reset;

    int rom_lat = 0;
    int rom_cnt = 0;
    int grants[$];
    int exp_order[4] = '{2, 3, 0, 1};

    always #5 clk = ~clk;

    always_comb begin
        ch_code = '0;
        ch_row  = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_code[i*CW +: CW] = code[i];
            ch_row[i*RW +: RW]  = row[i];
        end
    end

    tile_rom_fetch_arbiter dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_ack(ch_ack),
        .ch_code(ch_code), .ch_row(ch_row), .ch_flipy(ch_flipy),
        .cache_flush(cache_flush), .rom_address(rom_address), .rom_req(rom_req),
        .rom_ack(rom_ack), .rom_data(rom_data), .load(load), .load_ch(load_ch),
        .load_data(load_data), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int w);
        int r;
        r = ch_flipy[w] ? (15 - int'(row[w])) : int'(row[w]);
        return AW'(int'(code[w]) * 128 + r * 8);
    endfunction

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        if (a == 23'h091D0) return 64'hDEADBEEF_01234567;
        return {9'h0, a, 9'h1A5, a} ^ 64'h5A5A_0000_0000_C3C3;
    endfunction

    task automatic serve(input int w, input logic [DW-1:0] d);
        m_load      = 1'b1;
        m_load_ch   = w;
        m_load_data = d;
        m_ack[w]    = ~m_ack[w];
    endtask

    // Transaction-level reference: what the arbiter owes after this edge.
    task automatic model_edge();
        int w;
        logic [AW-1:0] a;
        m_new_fetch   = 1'b0;
        m_after_reset = 1'b0;
        if (reset) begin
            m_ack = ch_req; m_romreq = rom_ack; m_addr = '0;
            m_load = 1'b0; m_load_ch = 0; m_load_data = '0; m_busy = 1'b0;
            m_rr = 0; m_valid = 1'b0; m_out = -1; m_after_reset = 1'b1;
            return;
        end
        m_load = 1'b0;
        if (m_out < 0) begin
            w = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_rr + k) % NCH;
                if (w < 0 && ch_req[c] != m_ack[c]) w = c;
            end
            if (w >= 0) begin
                a = addr_of(w);
                m_rr = (w + 1) % NCH;
                if ((code[w] & 16'h7FFF) == 16'h0) serve(w, '0);
                else if (m_valid && m_tag == a && !cache_flush) serve(w, m_cdata);
                else begin
                    m_addr = a; m_romreq = ~m_romreq; m_busy = 1'b1;
                    m_out = w; m_out_addr = a; m_new_fetch = 1'b1;
                end
            end
        end else if (rom_ack == m_romreq) begin
            serve(m_out, rom_data);
            m_busy = 1'b0; m_valid = 1'b1; m_tag = m_out_addr; m_cdata = rom_data;
            m_out = -1;
        end
        if (cache_flush) m_valid = 1'b0;
    endtask

    task automatic check_outputs();
        chk("ch_ack", 64'(ch_ack), 64'(m_ack));
        chk("rom_req", 64'(rom_req), 64'(m_romreq));
        chk("rom_address", 64'(rom_address), 64'(m_addr));
        chk("load", 64'(load), 64'(m_load));
        chk("busy", 64'(busy), 64'(m_busy));
        if (m_load || m_after_reset) begin
            chk("load_ch", 64'(load_ch), 64'(m_load_ch));
            chk("load_data", load_data, m_load_data);
        end
    endtask

    // ROM side: ack the outstanding fetch rom_lat cycles after it is issued.
    task automatic rom_emulate();
        if (m_new_fetch) rom_cnt = rom_lat;
        if (m_out >= 0 && rom_ack != m_romreq) begin
            if (rom_cnt == 0) begin
                rom_data = rom_fn(m_addr);
                rom_ack  = m_romreq;
            end else rom_cnt--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (load === 1'b1) grants.push_back(int'(load_ch));
        @(negedge clk);
        rom_emulate();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && m_busy; i++) tick();
        chk(tag, 64'(busy), 64'(1'b0));
    endtask

    function automatic logic [CW-1:0] pick_code();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h0123;
            3: return 16'h0042;
            default: return CW'($urandom);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < NCH; i++) begin code[i] = 16'h0001; row[i] = '0; end
        ch_req = 4'b0110;

        // reset
        reset = 1'b1;
        tick(); tick();
        chk("rst_ack", 64'(ch_ack), 64'(4'b0110));
        chk("rst_romreq", 64'(rom_req), 64'(1'b1));
        reset = 1'b0;

        // blank bypass
        code[0] = 16'h8000; row[0] = 4'd3; ch_req[0] = ~ch_req[0];
        tick();
        chk("blank_load", 64'(load), 64'(1'b1));
        chk("blank_ch", 64'(load_ch), 64'(0));
        chk("blank_data", load_data, 64'h0);
        chk("blank_romreq", 64'(rom_req), 64'(1'b1));

        // miss with flip
        code[2] = 16'h0123; row[2] = 4'h5; ch_flipy[2] = 1'b1; rom_lat = 7;
        ch_req[2] = ~ch_req[2];
        tick();
        chk("miss_addr", 64'(rom_address), 64'(23'h091D0));
        chk("miss_busy", 64'(busy), 64'(1'b1));
        wait_idle("miss_done");
        chk("miss_ch", 64'(load_ch), 64'(2));
        chk("miss_data", load_data, 64'hDEADBEEF_01234567);

        // cache hit, then forced miss by flush
        code[1] = 16'h0123; row[1] = 4'h5; ch_flipy[1] = 1'b1; ch_req[1] = ~ch_req[1];
        tick();
        chk("hit_load", 64'(load), 64'(1'b1));
        chk("hit_data", load_data, 64'hDEADBEEF_01234567);
        chk("hit_nobusy", 64'(busy), 64'(1'b0));
        ch_req[1] = ~ch_req[1]; cache_flush = 1'b1;
        tick();
        cache_flush = 1'b0;
        chk("flush_miss", 64'(busy), 64'(1'b1));
        wait_idle("flush_done");

        // round-robin from rr_ptr=2
        for (int i = 0; i < NCH; i++) begin
            code[i] = CW'(16'h0011 * (i + 1)); row[i] = '0; ch_flipy[i] = 1'b0;
        end
        rom_lat = 2;
        grants.delete();
        ch_req = ~ch_req;
        for (int i = 0; i < 200 && (m_busy || ch_req != m_ack); i++) tick();
        chk("rr_count", 64'(grants.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < grants.size()) chk("rr_order", 64'(grants[i]), 64'(exp_order[i]));
        chk("rr_acks", 64'(ch_ack), 64'(ch_req));

        // arrival during WAIT
        code[0] = 16'h0055; rom_lat = 4; ch_req[0] = ~ch_req[0];
        tick();
        code[3] = 16'h0066; ch_req[3] = ~ch_req[3];
        for (int i = 0; i < 60 && m_busy; i++) tick();
        chk("arr_first_ch", 64'(load_ch), 64'(0));
        tick();
        chk("arr_grant_busy", 64'(busy), 64'(1'b1));
        chk("arr_grant_addr", 64'(rom_address), 64'(23'h3300));
        wait_idle("arr_done");
        chk("arr_second_ch", 64'(load_ch), 64'(3));

        // reset mid-fetch
        code[1] = 16'h0077; ch_flipy[1] = 1'b0; row[1] = '0; rom_lat = 10;
        ch_req[1] = ~ch_req[1];
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_busy", 64'(busy), 64'(1'b0));
        chk("rmid_load", 64'(load), 64'(1'b0));
        chk("rmid_ack", 64'(ch_ack), 64'(ch_req));
        chk("rmid_romreq", 64'(rom_req), 64'(rom_ack));
        code[2] = 16'h0066; row[2] = '0; ch_flipy[2] = 1'b0; rom_lat = 1;
        ch_req[2] = ~ch_req[2];
        tick();
        chk("rmid_refetch", 64'(busy), 64'(1'b1));
        wait_idle("rmid_done");

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cache_flush = ($urandom_range(0, 19) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            rom_lat     = $urandom_range(0, 4);
            for (int c = 0; c < NCH; c++) begin
                if (ch_req[c] == m_ack[c] && $urandom_range(0, 3) == 0) begin
                    code[c]     = pick_code();
                    row[c]      = RW'($urandom_range(0, 3));
                    ch_flipy[c] = 1'($urandom_range(0, 1));
                    ch_req[c]   = ~ch_req[c];
                end
            end
            tick();
        end
        reset = 1'b0; cache_flush = 1'b0;
        for (int i = 0; i < 60 && m_busy; i++) tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
